// File: rtl/fetch_sequencer_pkg.sv
// Shared parameters for the instruction fetch path.
//   INSTRUCTION_WIDTH : instruction word width
//   FETCH_ADDR_WIDTH  : default instruction address width
//   fetch_state_t     : sequencer FSM encoding (IDLE=0, REQ=1, DISCARD=2)
//   count_width()     : width of an occupancy counter for a given depth
package fetch_sequencer_pkg;

    localparam int INSTRUCTION_WIDTH = 26;
    localparam int FETCH_ADDR_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Holds 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: memory req/ack side, control valid/ready side,
// redirect/halt controls and buffer occupancy.
//   master : the sequencer
//   slave  : instruction memory plus control unit
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DEPTH      = 2
);
    localparam int CW = count_width(DEPTH);

    logic                         mem_req;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic                         mem_ack;
    logic [INSTRUCTION_WIDTH-1:0] mem_data;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]        instr_pc;
    logic                         instr_valid;
    logic                         instr_ready;
    logic                         redirect;
    logic [ADDR_WIDTH-1:0]        redirect_pc;
    logic                         halt;
    logic [CW-1:0]                buf_count;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid, buf_count,
        input  mem_ack, mem_data, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid, buf_count,
        output mem_ack, mem_data, instr_ready, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular buffer of {instr, pc}.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : append an entry
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : empty the buffer; overrides push and pop
//   rdata      : head entry, all-zero while empty
//   count      : occupancy 0..DEPTH
module fetch_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) slots[wr_ptr] <= wdata;
    end

    // Storage is not reset; gating on count gives zero outputs when empty.
    assign rdata = (count != '0) ? slots[rd_ptr] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Owns the PC, issues one read at a time over
// a req/ack handshake, buffers returned words in fetch_fifo and presents
// them to control over valid/ready. Redirects flush the buffer and turn an
// in-flight fetch into a discarded one.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_sequencer_if.master (memory, control, redirect, halt)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int CW = count_width(DEPTH);
    localparam int EW = INSTRUCTION_WIDTH + ADDR_WIDTH;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;
    logic                  push;
    logic                  pop;
    logic                  issue_ok;
    logic [CW:0]           count_next;
    logic [ADDR_WIDTH-1:0] pc_tgt;
    logic [ADDR_WIDTH-1:0] pc_ack;

    // Redirect outranks pop: the head shown in a redirect cycle is not taken.
    assign pop  = bus.instr_valid && bus.instr_ready && !bus.redirect;
    assign push = (state == REQ) && bus.mem_ack && !bus.redirect;

    // Occupancy after this edge; a redirect empties the buffer.
    assign count_next = bus.redirect ? '0
                      : {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

    // Only issue when a slot is reserved for the returning word.
    assign issue_ok = (count_next < (CW+1)'(DEPTH)) && !bus.halt;

    // Latest redirect wins; otherwise keep pc (IDLE/DISCARD) or step it (ack).
    assign pc_tgt = bus.redirect ? bus.redirect_pc : pc;
    assign pc_ack = bus.redirect ? bus.redirect_pc : pc + ADDR_WIDTH'(1);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata ({bus.mem_data, bus.mem_addr}),
        .rdata (head),
        .count (count)
    );

    assign bus.instr       = head[EW-1:ADDR_WIDTH];
    assign bus.instr_pc    = head[ADDR_WIDTH-1:0];
    assign bus.instr_valid = (count != '0);
    assign bus.buf_count   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    pc <= pc_tgt;
                    if (issue_ok) begin
                        state        <= REQ;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc_tgt;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        pc <= pc_ack;
                        if (issue_ok) begin
                            bus.mem_addr <= pc_ack;
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end else if (bus.redirect) begin
                        // Address stays on the bus until the old fetch acks.
                        state <= DISCARD;
                        pc    <= bus.redirect_pc;
                    end
                end
                DISCARD: begin
                    pc <= pc_tgt;
                    if (bus.mem_ack) begin
                        if (issue_ok) begin
                            state        <= REQ;
                            bus.mem_addr <= pc_tgt;
                        end else begin
                            state       <= IDLE;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int              AW    = 8;
    localparam int              DEPTH = 2;
    localparam int              IW    = INSTRUCTION_WIDTH;
    localparam int              CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   RST_A = 8'h00;
    localparam logic [AW-1:0]   RST_B = 8'hFE;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    int            lat;
    int            age_a = 0;
    int            age_b = 0;
    int            errors = 0;
    int            checks = 0;
    bit            done = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus_a ();
    fetch_sequencer_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus_b ();

    fetch_sequencer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RST_A)) u_a (
        .clk(clk), .reset(reset), .bus(bus_a.master));
    fetch_sequencer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RST_B)) u_b (
        .clk(clk), .reset(reset), .bus(bus_b.master));

    // Instruction memory contents as a function of address.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            8'h00:   return 26'h3140014;
            8'h01:   return 26'h3200016;
            8'h40:   return 26'h0A0A000;
            default: return {a, ~a, a, 2'b01};
        endcase
    endfunction

    // Memory acks once a request has waited lat cycles; lat=0 is zero-wait.
    assign bus_a.mem_ack  = bus_a.mem_req && (age_a >= lat);
    assign bus_b.mem_ack  = bus_b.mem_req && (age_b >= lat);
    assign bus_a.mem_data = bus_a.mem_ack ? mem_word(bus_a.mem_addr) : '1;
    assign bus_b.mem_data = bus_b.mem_ack ? mem_word(bus_b.mem_addr) : '1;
    assign bus_a.instr_ready = instr_ready;
    assign bus_b.instr_ready = instr_ready;
    assign bus_a.redirect    = redirect;
    assign bus_b.redirect    = redirect;
    assign bus_a.redirect_pc = redirect_pc;
    assign bus_b.redirect_pc = redirect_pc;
    assign bus_a.halt        = halt;
    assign bus_b.halt        = halt;

    always @(posedge clk) begin
        age_a <= (bus_a.mem_req && !bus_a.mem_ack) ? age_a + 1 : 0;
        age_b <= (bus_b.mem_req && !bus_b.mem_ack) ? age_b + 1 : 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per DUT: is a fetch outstanding, will its data be dropped, its address,
    // the next fetch address, and the PCs of buffered words (oldest first).
    bit            m_out  [2];
    bit            m_disc [2];
    logic [AW-1:0] m_addr [2];
    logic [AW-1:0] m_pc   [2];
    logic [AW-1:0] m_q    [2][DEPTH];
    int            m_n    [2];

    task automatic model_step(input int d, input logic ack);
        bit popv, pushv, can;
        if (reset) begin
            m_out[d]  = 1'b0;
            m_disc[d] = 1'b0;
            m_pc[d]   = d ? RST_B : RST_A;
            m_addr[d] = d ? RST_B : RST_A;
            m_n[d]    = 0;
            return;
        end
        popv  = (m_n[d] > 0) && instr_ready && !redirect;
        pushv = m_out[d] && !m_disc[d] && ack && !redirect;
        if (redirect) begin
            m_n[d] = 0;
        end else begin
            if (popv) begin
                for (int i = 0; i < DEPTH - 1; i++) m_q[d][i] = m_q[d][i+1];
                m_n[d]--;
            end
            if (pushv && m_n[d] < DEPTH) begin
                m_q[d][m_n[d]] = m_addr[d];
                m_n[d]++;
            end
        end
        can = (m_n[d] < DEPTH) && !halt;
        if (!m_out[d]) begin
            if (redirect) m_pc[d] = redirect_pc;
            if (can) begin
                m_out[d]  = 1'b1;
                m_addr[d] = m_pc[d];
            end
        end else if (ack) begin
            if (redirect)       m_pc[d] = redirect_pc;
            else if (!m_disc[d]) m_pc[d] = m_pc[d] + 8'd1;
            m_disc[d] = 1'b0;
            if (can) m_addr[d] = m_pc[d];
            else     m_out[d]  = 1'b0;
        end else if (redirect) begin
            m_disc[d] = 1'b1;
            m_pc[d]   = redirect_pc;
        end
    endtask

    task automatic compare(input int d, input logic req, input logic [AW-1:0] addr,
                           input logic valid, input logic [CW-1:0] cnt,
                           input logic [IW-1:0] ins, input logic [AW-1:0] ipc);
        check($sformatf("mem_req[%0d]", d), req, m_out[d]);
        if (m_out[d]) check($sformatf("mem_addr[%0d]", d), addr, m_addr[d]);
        check($sformatf("instr_valid[%0d]", d), valid, m_n[d] > 0);
        check($sformatf("buf_count[%0d]", d), cnt, m_n[d]);
        if (m_n[d] > 0) begin
            check($sformatf("instr_pc[%0d]", d), ipc, m_q[d][0]);
            check($sformatf("instr[%0d]", d), ins, mem_word(m_q[d][0]));
        end
    endtask

    // Model advances on the edge; outputs are compared half a cycle later.
    initial forever begin
        @(posedge clk);
        model_step(0, bus_a.mem_ack);
        model_step(1, bus_b.mem_ack);
        @(negedge clk);
        if (!done) begin
            compare(0, bus_a.mem_req, bus_a.mem_addr, bus_a.instr_valid, bus_a.buf_count,
                    bus_a.instr, bus_a.instr_pc);
            compare(1, bus_b.mem_req, bus_b.mem_addr, bus_b.instr_valid, bus_b.buf_count,
                    bus_b.instr, bus_b.instr_pc);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_fresh_req(input string name);
        bit found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            found = bus_a.mem_req && (age_a == 0);
        end
        check(name, found, 1'b1);
    endtask

    task automatic wait_ack(input string name);
        bit found = bus_a.mem_ack;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            found = bus_a.mem_ack;
        end
        check(name, found, 1'b1);
    endtask

    initial begin
        int  nreq;
        bit  found;
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; lat = 0;

        // Reset and stream
        repeat (3) @(negedge clk);
        check("rst_mem_req", bus_a.mem_req, 1'b0);
        check("rst_mem_addr", bus_a.mem_addr, RST_A);
        check("rst_mem_addr_b", bus_b.mem_addr, RST_B);
        check("rst_instr", bus_a.instr, '0);
        check("rst_instr_pc", bus_a.instr_pc, '0);
        check("rst_instr_valid", bus_a.instr_valid, 1'b0);
        check("rst_buf_count", bus_a.buf_count, '0);
        reset = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        check("start_req", bus_a.mem_req, 1'b1);
        check("start_addr", bus_a.mem_addr, 8'h00);
        check("no_bypass", bus_a.instr_valid, 1'b0);
        check("wrap_addr0", bus_b.mem_addr, 8'hFE);
        @(negedge clk);
        check("stream_instr0", bus_a.instr, 26'h3140014);
        check("stream_pc0", bus_a.instr_pc, 8'h00);
        check("stream_addr1", bus_a.mem_addr, 8'h01);
        check("wrap_addr1", bus_b.mem_addr, 8'hFF);
        @(negedge clk);
        check("stream_instr1", bus_a.instr, 26'h3200016);
        check("stream_pc1", bus_a.instr_pc, 8'h01);
        check("wrap_addr2", bus_b.mem_addr, 8'h00);
        check("wrap_pc_head", bus_b.instr_pc, 8'hFF);

        // Backpressure
        instr_ready = 1'b0;
        @(negedge clk);
        check("bp_full", bus_a.buf_count, 2'd2);
        check("bp_req_drop", bus_a.mem_req, 1'b0);
        repeat (2) @(negedge clk);
        check("bp_hold", bus_a.buf_count, 2'd2);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("bp_head_after_pop", bus_a.instr_pc, 8'h02);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_a.mem_req) nreq++;
            @(negedge clk);
        end
        check("bp_one_request", nreq, 1);

        // Redirect during a wait-state fetch
        instr_ready = 1'b1; lat = 3;
        wait_fresh_req("rd_wait_req");
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect = 1'b0;
        check("rd_flushed", bus_a.instr_valid, 1'b0);
        wait_ack("rd_late_ack");
        @(negedge clk);
        check("rd_new_req", bus_a.mem_req, 1'b1);
        check("rd_new_addr", bus_a.mem_addr, 8'h40);
        check("rd_still_empty", bus_a.instr_valid, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            found = bus_a.instr_valid;
        end
        check("rd_arrived", found, 1'b1);
        check("rd_instr", bus_a.instr, 26'h0A0A000);
        check("rd_pc", bus_a.instr_pc, 8'h40);

        // Redirect in the ack cycle with a pop
        lat = 0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            found = bus_a.instr_valid && bus_a.mem_ack;
        end
        check("ra_setup", found, 1'b1);
        redirect = 1'b1; redirect_pc = 8'h80;
        @(negedge clk);
        redirect = 1'b0;
        check("ra_empty", bus_a.instr_valid, 1'b0);
        check("ra_count", bus_a.buf_count, 2'd0);
        check("ra_addr", bus_a.mem_addr, 8'h80);
        check("ra_req", bus_a.mem_req, 1'b1);
        @(negedge clk);
        check("ra_first_pc", bus_a.instr_pc, 8'h80);

        // Halt while a request is outstanding
        lat = 3;
        wait_fresh_req("halt_req");
        @(negedge clk);
        halt = 1'b1;
        wait_ack("halt_ack");
        @(negedge clk);
        check("halt_pushed", bus_a.instr_valid, 1'b1);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_a.mem_req) nreq++;
            @(negedge clk);
        end
        check("halt_no_req", nreq, 0);
        halt = 1'b0;
        @(negedge clk);
        check("halt_release", bus_a.mem_req, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            instr_ready = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(0, 2);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3))
                                                      : 8'($urandom);
            halt        = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        redirect = 1'b0; halt = 1'b0; instr_ready = 1'b1;

        // Reset mid-request
        lat = 3;
        wait_fresh_req("mr_req");
        reset = 1'b1;
        @(negedge clk);
        check("mr_mem_req", bus_a.mem_req, 1'b0);
        check("mr_mem_addr", bus_a.mem_addr, RST_A);
        check("mr_mem_addr_b", bus_b.mem_addr, RST_B);
        check("mr_instr", bus_a.instr, '0);
        check("mr_instr_pc", bus_a.instr_pc, '0);
        check("mr_valid", bus_a.instr_valid, 1'b0);
        check("mr_count", bus_a.buf_count, '0);
        reset = 1'b0; halt = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_stays_empty", bus_a.instr_valid, 1'b0);

        @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer between instruction memory and the datapath's control unit. It owns the program counter and issues one-at-a-time read requests over a req/ack memory handshake. Fetched words are buffered in a small prefetch FIFO and presented to control through a valid/ready interface. Branch redirects flush the buffer and any in-flight fetch, so control sees only instructions on the correct path.

## Interface
- INSTRUCTION_WIDTH, 26: instruction word width; the value comes from the shared parameters file.
- ADDR_WIDTH, 8: instruction address width.
- DEPTH, 2: prefetch FIFO entries; must be a power of 2, at least 2.
- RESET_PC, 0: PC loaded on reset.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_WIDTH  address of the current request.
- mem_ack  in  1  memory completes the request this cycle.
- mem_data  in  INSTRUCTION_WIDTH  read data; valid only when mem_ack=1.
- instr  out  INSTRUCTION_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  address of the FIFO head.
- instr_valid  out  1  FIFO is non-empty.
- instr_ready  in  1  control accepts the head this cycle.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  ADDR_WIDTH  branch target.
- halt  in  1  do not start new fetches.
- buf_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **States:**
  - IDLE: no request.
  - REQ: request outstanding, data kept.
  - DISCARD: request outstanding, data to be dropped.
- **Outputs:** mem_req=1 in REQ and DISCARD. mem_addr is held stable from the cycle mem_req rises until the mem_ack cycle.
- **Pop:** occurs when instr_valid & instr_ready & !redirect.
- **Push:** occurs when state=REQ & mem_ack & !redirect. It writes {mem_data, mem_addr}.
- **count_next:** count + push − pop. Simultaneous push and pop is legal, including when full or empty-with-push.
- **Issue rule:** a new request starts next cycle only if count_next < DEPTH and !halt. This guarantees a FIFO slot for every in-flight request, so the FIFO never overflows.
- **IDLE:**
  - If issue is allowed, go to REQ with mem_addr=pc.
- **REQ without ack:**
  - redirect → DISCARD; pc := redirect_pc.
  - Otherwise stay in REQ.
- **REQ with ack:**
  - pc := pc+1, wrapping modulo 2^ADDR_WIDTH; 0xFF+1 = 0x00.
  - If issue is allowed, stay in REQ with the new address (back-to-back); otherwise go to IDLE.
- **REQ with ack and redirect in the same cycle:** data is dropped, pc := redirect_pc, next state is REQ (or IDLE if halt).
- **DISCARD:**
  - On ack, data is dropped and the next state is REQ at pc (or IDLE if halt).
  - A further redirect while in DISCARD overwrites pc; the latest redirect wins.
- **Redirect in any state:** the FIFO is cleared at that edge, so instr_valid=0 next cycle. Redirect has priority over pop, and an instruction presented in the redirect cycle is not consumed.
- **halt:**
  - Only blocks new issues.
  - An outstanding request still completes and is pushed.
  - The FIFO still drains.
- **Reset:**
  - Abandons any in-flight request: mem_req=0 the next cycle. Instruction memory tolerates an abandoned request.

## Timing
- **Reset values:** mem_req=0, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, buf_count=0, state=IDLE, pc=RESET_PC.
- **Startup:** with reset low at edge N, mem_req=1 after edge N.
- **Fetch latency:** ack at edge M makes instr_valid=1 after edge M. The FIFO has no bypass.
- **Throughput:** 1 instruction per cycle with a zero-wait memory (ack in the same cycle as req) and instr_ready held high.
- **Redirect-to-request:**
  - Redirect at edge R with no request outstanding: mem_addr=redirect_pc after edge R.
  - Redirect with a request outstanding: the new request follows 1 cycle after the discarded ack.
- instr, instr_pc and instr_valid are driven from registered FIFO state only; they have no combinational path from memory inputs.

## Structure
- The shared parameters file holds:
  - State encodings: IDLE=0, REQ=1, DISCARD=2, on 2 bits.
  - INSTRUCTION_WIDTH.
  - The fetch ADDR_WIDTH default.
- One sub-module, fetch_fifo:
  - DEPTH-entry circular buffer of {instr, pc}.
  - push, pop and flush inputs; count output.
  - Pointers wrap modulo DEPTH.
  - flush has priority over push and pop.
- fetch_sequencer contains the FSM, the PC register and the issue logic.

## Test plan
- **Reset and stream:** assert reset for 3 cycles, then release. Memory is zero-wait, returning 'h3140014 then 'h3200016; instr_ready=1. Expect:
  - mem_addr 0,1,2…
  - instr 'h3140014 with instr_pc=0, then 'h3200016 with instr_pc=1, on consecutive cycles.
- **Backpressure:** instr_ready=0 with a zero-wait memory. Expect:
  - buf_count rises to 2; mem_req drops after the second ack.
  - Raising instr_ready for one cycle produces exactly one new request.
  - No data is lost or duplicated.
- **Redirect during a wait-state fetch:** memory acks 3 cycles late; redirect to 'h40 in the second wait cycle. Expect:
  - The late ack data is discarded.
  - The next mem_addr is 'h40.
  - instr_valid stays 0 until 'h0A0A000 from 'h40 arrives.
- **Redirect in the ack cycle, with a simultaneous pop:** expect the FIFO empty next cycle, the acked data absent, and mem_addr=redirect_pc.
- **Wrap and halt:**
  - Start at RESET_PC='hFE. Expect fetch addresses 'hFE, 'hFF, 'h00.
  - Assert halt while in REQ. Expect the request to complete and be pushed, then mem_req=0 until halt is released.
- **Reset mid-request:** assert reset while mem_req=1 with no ack. Expect the reset values listed under Timing the next cycle; the FIFO stays empty.
